// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake, one divide in flight at a time.

module seq_restoring_divider_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_out,
  output logic [WIDTH-1:0] q_out
);
  logic [WIDTH+1:0] t;
  logic             borrow;

  // r_in[WIDTH] is always 0 between steps, so widening the subtract by one bit
  // gives the same borrow as the (WIDTH+1)-bit trial subtraction.
  assign t      = {r_in, q_in[WIDTH-1]} - {2'b00, d};
  assign borrow = t[WIDTH+1];
  assign r_out  = borrow ? {r_in[WIDTH-1:0], q_in[WIDTH-1]} : t[WIDTH:0];
  assign q_out  = {q_in[WIDTH-2:0], ~borrow};
endmodule

module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r_q, r_nxt;
  logic [WIDTH-1:0] q_q, q_nxt;
  logic [WIDTH-1:0] d_q;

  seq_restoring_divider_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (r_q),
    .q_in  (q_q),
    .d     (d_q),
    .r_out (r_nxt),
    .q_out (q_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          d_q <= divisor;
          q_q <= dividend;
          r_q <= '0;
          cnt <= '0;
          // Zero divisor skips the iteration and reports a saturated quotient.
          if (divisor == '0) begin
            state       <= DONE;
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          r_q <= r_nxt;
          q_q <= q_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state       <= DONE;
            quotient    <= q_nxt;
            remainder   <= r_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CALC) || (state == DONE);
  assign done = (state == DONE);
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and boundary-grid checks of the sequential restoring divider
// against hand-computed values and an integer reference.

module tb_seq_restoring_divider;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [WIDTH-1:0] dividend, divisor;
  logic             busy, done, div_by_zero;
  logic [WIDTH-1:0] quotient, remainder;

  int nvec = 0;
  int nerr = 0;

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Launch one divide with start held for 'hold' cycles; observe a fixed window.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int hold,
                         output logic [7:0] q, output logic [7:0] r, output logic dz,
                         output int lat, output int ndone, output logic busy_after);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    lat = -1; ndone = 0; q = '0; r = '0; dz = 1'b0; busy_after = 1'b1;
    for (int c = 1; c <= hold + WIDTH + 3; c++) begin
      @(posedge clk); #1;
      if (c >= hold) start = 1'b0;
      if (done && c <= WIDTH + 2) begin
        ndone++;
        if (lat < 0) begin
          lat = c; q = quotient; r = remainder; dz = div_by_zero;
        end
      end
      if (c == WIDTH + 2) busy_after = busy;
    end
  endtask

  task automatic check_div(input logic [7:0] a, input logic [7:0] b, input string tag);
    logic [7:0] q, r, eq, er;
    logic dz, ba;
    int lat, nd;
    eq = (b == 0) ? 8'hFF : 8'(a / b);
    er = (b == 0) ? a : 8'(a % b);
    run_div(a, b, 1, q, r, dz, lat, nd, ba);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
    chk({tag, "_dz"}, dz, (b == 0));
    chk({tag, "_lat"}, lat, (b == 0) ? 1 : WIDTH + 1);
    chk({tag, "_ndone"}, nd, 1);
    chk({tag, "_hold_q"}, quotient, eq);
    if (b != 0) begin
      chk({tag, "_inv"}, 32'(q) * 32'(b) + 32'(r), 32'(a));
      chk({tag, "_rltd"}, (r < b), 1);
    end
  endtask

  initial begin
    logic [7:0] q, r;
    logic dz, ba;
    int lat, nd;
    logic [7:0] edges [12] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd15, 8'd16,
                               8'd127, 8'd128, 8'd200, 8'd254, 8'd255};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    @(negedge clk); rst = 1'b0;

    check_div(8'd200, 8'd13, "d200_13");
    check_div(8'd255, 8'd1,  "d255_1");
    check_div(8'd7,   8'd9,  "d7_9");
    check_div(8'd0,   8'd5,  "d0_5");
    check_div(8'd225, 8'd15, "d225_15");
    check_div(8'd100, 8'd0,  "d100_0");
    check_div(8'd10,  8'd3,  "d10_3");

    // Start held across the whole divide: one result, DONE ignores start.
    run_div(8'd50, 8'd7, 12, q, r, dz, lat, nd, ba);
    chk("hold_ndone", nd, 1);
    chk("hold_q", q, 7);
    chk("hold_r", r, 1);
    chk("hold_lat", lat, WIDTH + 1);
    chk("hold_busy_after_done", ba, 0);
    begin : drain
      int w = 0;
      while (busy && w < 40) begin @(posedge clk); #1; w++; end
      chk("hold_drain", busy, 0);
    end

    // Reset mid-divide.
    @(negedge clk);
    dividend = 8'd200; divisor = 8'd13; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_q", quotient, 0);
    chk("mid_rst_r", remainder, 0);
    @(negedge clk); rst = 1'b0;
    check_div(8'd9, 8'd2, "d9_2");

    foreach (edges[i])
      foreach (edges[j])
        check_div(edges[i], edges[j], "grid");

    for (int k = 0; k < 200; k++)
      check_div(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rand");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
